hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//  Parametrised HI/LO register pair with integrated multi-cycle multiply/divide engine.
//  Replaces the plain HI/LO register file in EX/MEM: accepts MULT/MULTU/DIV/DIVU/MADD/MSUB
//  and MTHI/MTLO ops via valid/ready, owns HI/LO state, and serves MFHI/MFLO reads.
//  Reads are write-forwarded; the pipeline stalls on busy_o.
// PARAMETERS
//  WIDTH        32  data width of HI, LO and operands (even, >=8)
//  MUL_LATENCY  2   accept-to-HI/LO-update cycles for MULT/MULTU/MADD/MSUB (>=1)
//  ENABLE_MACC  1   1: MADD/MSUB implemented; 0: those opcodes ignored (accepted, no effect)
// PORTS
//  clock_i           in   1      rising-edge clock
//  reset_i           in   1      asynchronous, active-high reset
//  op_valid_i        in   1      operation request
//  op_ready_o        out  1      unit can accept (state IDLE)
//  op_code_i         in   3      0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6 MADD,7 MSUB
//  src_a_i           in   WIDTH  rs operand / MTHI-MTLO data / dividend
//  src_b_i           in   WIDTH  rt operand / divisor
//  flush_i           in   1      abort in-flight op (exception/branch flush)
//  busy_o            out  1      multi-cycle op in flight (= ~op_ready_o)
//  done_o            out  1      one-cycle pulse: HI/LO updated by multi-cycle op on last edge
//  hilo_read_addr_i  in   1      1 = HI, 0 = LO
//  hilo_read_data_o  out  WIDTH  selected register, forwarded
// BEHAVIOUR
//  Reset (async): HI=LO=0, state IDLE, op_ready_o=1, busy_o=0, done_o=0, counters 0.
//  Accept = op_valid_i & op_ready_o & ~flush_i. flush_i same cycle as valid: op dropped.
//  MTHI/MTLO: single cycle; register written on accepting edge; state stays IDLE.
//  MULT/MULTU/MADD/MSUB: operands latched on accept edge; state MUL; {HI,LO} written on
//   edge MUL_LATENCY after accept. MULT signed, MULTU unsigned, 2*WIDTH product.
//   MADD/MSUB: {HI,LO} +/- signed product, using HI/LO as of the write edge, mod 2^(2*WIDTH).
//  DIV/DIVU: state DIV. Accept edge latches |a|,|b| (signed) or raw (unsigned) and signs.
//   Restoring radix-2, one quotient bit per edge for WIDTH edges, then one fix-up edge:
//   negate quotient if signs differ, negate remainder if dividend negative; LO=quot, HI=rem.
//   Total WIDTH+1 edges after accept (33 at WIDTH=32).
//   Divisor 0: no iteration; next edge returns IDLE, HI/LO unchanged, done_o pulses.
//   Signed MIN / -1: LO=MIN, HI=0 (natural wrap, no trap).
//  done_o: registered, high for exactly the cycle after the HI/LO-updating edge; op_ready_o
//   already 1 in that cycle (back-to-back accept allowed). Not asserted for MTHI/MTLO.
//  flush_i while MUL/DIV: next edge -> IDLE, HI/LO unchanged, no done_o. flush_i in IDLE: no-op.
//  Read path combinational: HI sel -> accepted-MTHI data this cycle, else HI; LO likewise.
//   Multi-cycle results visible from the cycle after the write edge (no forward from engine).
//  States: IDLE -> MUL (mul ops) | DIV (div ops); MUL/DIV -> IDLE on completion or flush.
//  op_valid_i while busy: ignored (requester must hold until op_ready_o).
// STRUCTURE
//  hilo_pkg: opcode localparams (OP_MULT..OP_MSUB), state encoding (ST_IDLE/ST_MUL/ST_DIV).
//  Sub-module hilo_divider: iterative restoring divider (start, a, b, signed_i -> busy,
//   done, quot, rem, div_by_zero); WIDTH parameter; flush via abort_i.
//  Multiplier: inline product + MUL_LATENCY-deep pipeline/valid shift register.
// TESTING
//  1 reset mid-DIV (cycle 10) -> HI=LO=0, op_ready_o=1 immediately, no done_o.
//  2 MTHI 0xDEADBEEF, same cycle read HI -> 0xDEADBEEF; next cycle HI reg=0xDEADBEEF, LO kept.
//  3 MULT 0xFFFFFFFF*2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE at edge 2; MULTU same -> HI=1, LO=0xFFFFFFFE.
//  4 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, done_o 33 cycles after accept; DIVU 7/0 -> HI/LO kept, done next cycle.
//  5 DIV 0x80000000/-1 -> LO=0x80000000, HI=0; MADD HI:LO=0:1 + 3*-1 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
//  6 flush_i at DIV cycle 5 -> IDLE next edge, HI/LO unchanged, no done_o; valid+flush same cycle -> dropped.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared opcode and state encodings for the HI/LO multiply/divide unit.
package hilo_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MADD  = 3'd6;
   localparam logic [2:0] OP_MSUB  = 3'd7;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;

   function automatic logic is_mul_op(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/hilo_divider.sv
// Iterative restoring radix-2 divider: one quotient bit per edge, then one
// sign fix-up cycle during which done is high and the corrected results are presented.
module hilo_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort_i,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_i,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   logic             run_q;
   logic             fix_q;
   logic             zero_q;
   logic             quot_neg_q;
   logic             rem_neg_q;
   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] div_q;
   logic [CW-1:0]    count_q;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH:0]   shifted;
   logic             fits;
   logic [WIDTH-1:0] trial;

   assign a_neg = signed_i & a[WIDTH-1];
   assign b_neg = signed_i & b[WIDTH-1];

   // The partial remainder is always below the divisor, so once the subtraction
   // is known to fit, the low WIDTH bits hold the exact difference.
   assign shifted = {rem_q, quot_q[WIDTH-1]};
   assign fits    = (shifted >= {1'b0, div_q});
   assign trial   = shifted[WIDTH-1:0] - div_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q      <= 1'b0;
         fix_q      <= 1'b0;
         zero_q     <= 1'b0;
         quot_neg_q <= 1'b0;
         rem_neg_q  <= 1'b0;
         quot_q     <= '0;
         rem_q      <= '0;
         div_q      <= '0;
         count_q    <= '0;
      end else if (abort_i) begin
         run_q  <= 1'b0;
         fix_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (start) begin
         quot_q     <= a_neg ? -a : a;
         div_q      <= b_neg ? -b : b;
         rem_q      <= '0;
         count_q    <= CW'(WIDTH - 1);
         quot_neg_q <= a_neg ^ b_neg;
         rem_neg_q  <= a_neg;
         zero_q     <= (b == '0);
         run_q      <= (b != '0);
         fix_q      <= 1'b0;
      end else if (run_q) begin
         rem_q  <= fits ? trial : shifted[WIDTH-1:0];
         quot_q <= {quot_q[WIDTH-2:0], fits};
         if (count_q == '0) begin
            run_q <= 1'b0;
            fix_q <= 1'b1;
         end else begin
            count_q <= count_q - 1'b1;
         end
      end else begin
         fix_q  <= 1'b0;
         zero_q <= 1'b0;
      end
   end

   assign busy        = run_q | fix_q | zero_q;
   assign done        = fix_q | zero_q;
   assign div_by_zero = zero_q;
   assign quot        = quot_neg_q ? -quot_q : quot_q;
   assign rem         = rem_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with multi-cycle multiply / multiply-accumulate / divide
// engine and a write-forwarded MFHI/MFLO read port.
module hilo_muldiv_unit
   import hilo_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MUL_LATENCY = 2,
   parameter int ENABLE_MACC = 1
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             op_valid_i,
   output logic             op_ready_o,
   input  logic [2:0]       op_code_i,
   input  logic [WIDTH-1:0] src_a_i,
   input  logic [WIDTH-1:0] src_b_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   input  logic             hilo_read_addr_i,
   output logic [WIDTH-1:0] hilo_read_data_o
);

   logic [1:0]             state_q;
   logic [WIDTH-1:0]       hi_q;
   logic [WIDTH-1:0]       lo_q;
   logic [WIDTH-1:0]       mul_a_q;
   logic [WIDTH-1:0]       mul_b_q;
   logic [2:0]             mul_op_q;
   logic [MUL_LATENCY-1:0] mul_pipe_q;
   logic                   done_q;

   logic                   accept;
   logic                   macc_ok;
   logic                   mul_go;
   logic                   div_go;
   logic                   mul_signed;
   logic [2*WIDTH-1:0]     ext_a;
   logic [2*WIDTH-1:0]     ext_b;
   logic [2*WIDTH-1:0]     product;
   logic [2*WIDTH-1:0]     mul_result;

   logic                   div_busy;
   logic                   div_done;
   logic                   div_zero;
   logic [WIDTH-1:0]       div_quot;
   logic [WIDTH-1:0]       div_rem;

   assign op_ready_o = (state_q == ST_IDLE);
   assign accept     = op_valid_i & op_ready_o & ~flush_i;
   assign macc_ok    = (ENABLE_MACC != 0);
   // With MACC disabled, MADD/MSUB are accepted but leave the unit idle.
   assign mul_go     = accept & is_mul_op(op_code_i) &
                       (macc_ok | (op_code_i == OP_MULT) | (op_code_i == OP_MULTU));
   assign div_go     = accept & is_div_op(op_code_i);

   // NOTE: every signal driven here gets a default first, so no path leaves
   // a value held and no latch is inferred.
   always_comb begin
      mul_signed = (mul_op_q != OP_MULTU);
      ext_a      = mul_signed ? {{WIDTH{mul_a_q[WIDTH-1]}}, mul_a_q} : {{WIDTH{1'b0}}, mul_a_q};
      ext_b      = mul_signed ? {{WIDTH{mul_b_q[WIDTH-1]}}, mul_b_q} : {{WIDTH{1'b0}}, mul_b_q};
      product    = ext_a * ext_b;
      mul_result = product;
      case (mul_op_q)
         OP_MADD: mul_result = {hi_q, lo_q} + product;
         OP_MSUB: mul_result = {hi_q, lo_q} - product;
         default: mul_result = product;
      endcase
   end

   hilo_divider #(
      .WIDTH(WIDTH)
   ) u_divider (
      .clk         (clock_i),
      .rst         (reset_i),
      .start       (div_go),
      .abort_i     (flush_i & (state_q == ST_DIV)),
      .a           (src_a_i),
      .b           (src_b_i),
      .signed_i    (op_code_i == OP_DIV),
      .busy        (div_busy),
      .done        (div_done),
      .quot        (div_quot),
      .rem         (div_rem),
      .div_by_zero (div_zero)
   );

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         hi_q       <= '0;
         lo_q       <= '0;
         mul_a_q    <= '0;
         mul_b_q    <= '0;
         mul_op_q   <= OP_MULT;
         mul_pipe_q <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept && op_code_i == OP_MTHI) hi_q <= src_a_i;
               if (accept && op_code_i == OP_MTLO) lo_q <= src_a_i;
               if (mul_go) begin
                  mul_a_q    <= src_a_i;
                  mul_b_q    <= src_b_i;
                  mul_op_q   <= op_code_i;
                  mul_pipe_q <= MUL_LATENCY'(1);
                  state_q    <= ST_MUL;
               end
               if (div_go) state_q <= ST_DIV;
            end
            ST_MUL: begin
               if (flush_i) begin
                  mul_pipe_q <= '0;
                  state_q    <= ST_IDLE;
               end else begin
                  mul_pipe_q <= mul_pipe_q << 1;
                  if (mul_pipe_q[MUL_LATENCY-1]) begin
                     {hi_q, lo_q} <= mul_result;
                     done_q       <= 1'b1;
                     state_q      <= ST_IDLE;
                  end
               end
            end
            ST_DIV: begin
               if (flush_i) begin
                  state_q <= ST_IDLE;
               end else if (div_done) begin
                  if (!div_zero) {hi_q, lo_q} <= {div_rem, div_quot};
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Only MTHI/MTLO data is forwarded; engine results appear after their write edge.
   always_comb begin
      if (hilo_read_addr_i)
         hilo_read_data_o = (accept && op_code_i == OP_MTHI) ? src_a_i : hi_q;
      else
         hilo_read_data_o = (accept && op_code_i == OP_MTLO) ? src_a_i : lo_q;
   end

   assign busy_o = (state_q == ST_MUL) | div_busy;
   assign done_o = done_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed and randomized bench for hilo_muldiv_unit against an arithmetic HI/LO model.
module tb_hilo_muldiv_unit;
   import hilo_pkg::*;

   localparam int W  = 32;
   localparam int ML = 2;

   logic          clock_i = 1'b0;
   logic          reset_i;
   logic          op_valid_i;
   logic          op_ready_o;
   logic [2:0]    op_code_i;
   logic [W-1:0]  src_a_i;
   logic [W-1:0]  src_b_i;
   logic          flush_i;
   logic          busy_o;
   logic          done_o;
   logic          hilo_read_addr_i;
   logic [W-1:0]  hilo_read_data_o;

   int            n_assert = 0;
   int            n_fail   = 0;
   logic [31:0]   model_hi;
   logic [31:0]   model_lo;

   hilo_muldiv_unit #(
      .WIDTH      (W),
      .MUL_LATENCY(ML),
      .ENABLE_MACC(1)
   ) dut (
      .clock_i         (clock_i),
      .reset_i         (reset_i),
      .op_valid_i      (op_valid_i),
      .op_ready_o      (op_ready_o),
      .op_code_i       (op_code_i),
      .src_a_i         (src_a_i),
      .src_b_i         (src_b_i),
      .flush_i         (flush_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .hilo_read_addr_i(hilo_read_addr_i),
      .hilo_read_data_o(hilo_read_data_o)
   );

   always #5 clock_i = ~clock_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_assert++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
      hilo_read_addr_i = 1'b1;
      #1 hi = hilo_read_data_o;
      hilo_read_addr_i = 1'b0;
      #1 lo = hilo_read_data_o;
   endtask

   task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      logic [31:0] hi, lo;
      read_hilo(hi, lo);
      check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
      check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
      op_valid_i = 1'b1;
      op_code_i  = op;
      src_a_i    = a;
      src_b_i    = b;
      flush_i    = fl;
      check("ready_at_issue", 64'(op_ready_o), 64'd1);
      tick();
      op_valid_i = 1'b0;
      flush_i    = 1'b0;
   endtask

   // Ticks until done_o is seen; cycles counts edges since the accept edge.
   task automatic wait_done(input int budget, output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (done_o !== 1'b1 && cycles < budget);
      check("done_within_budget", 64'(done_o), 64'd1);
   endtask

   task automatic expect_no_done(input string tag, input int n);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (done_o === 1'b1) seen = 1'b1;
         tick();
      end
      check(tag, 64'(seen), 64'd0);
   endtask

   // Updates the model and returns cycles from accept to done_o (0: no done).
   function automatic int model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] acc;
      logic [63:0] sprod;
      longint      q;
      longint      r;
      int          lat;
      acc   = {model_hi, model_lo};
      sprod = 64'(longint'($signed(a)) * longint'($signed(b)));
      lat   = ML;
      case (op)
         OP_MULT:  acc = sprod;
         OP_MULTU: acc = {32'd0, a} * {32'd0, b};
         OP_MADD:  acc = acc + sprod;
         OP_MSUB:  acc = acc - sprod;
         OP_DIV: begin
            if (b == 32'd0) lat = 1;
            else begin
               q   = longint'($signed(a)) / longint'($signed(b));
               r   = longint'($signed(a)) % longint'($signed(b));
               acc = {r[31:0], q[31:0]};
               lat = W + 1;
            end
         end
         OP_DIVU: begin
            if (b == 32'd0) lat = 1;
            else begin
               acc = {a % b, a / b};
               lat = W + 1;
            end
         end
         OP_MTHI: begin acc[63:32] = a; lat = 0; end
         default: begin acc[31:0]  = a; lat = 0; end
      endcase
      model_hi = acc[63:32];
      model_lo = acc[31:0];
      return lat;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'(($urandom_range(0, 40)));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int          cyc;
      int          lat;
      logic [2:0]  op;
      logic [31:0] a, b;

      reset_i          = 1'b1;
      op_valid_i       = 1'b0;
      op_code_i        = OP_MULT;
      src_a_i          = '0;
      src_b_i          = '0;
      flush_i          = 1'b0;
      hilo_read_addr_i = 1'b0;
      model_hi         = '0;
      model_lo         = '0;
      repeat (2) tick();
      reset_i = 1'b0;
      tick();

      check("reset_ready", 64'(op_ready_o), 64'd1);
      check("reset_busy",  64'(busy_o),     64'd0);
      check("reset_done",  64'(done_o),     64'd0);
      check_hilo("reset", 32'd0, 32'd0);

      // MTHI with same-cycle forwarded read
      op_valid_i       = 1'b1;
      op_code_i        = OP_MTHI;
      src_a_i          = 32'hDEAD_BEEF;
      hilo_read_addr_i = 1'b1;
      #1 check("mthi_forward", 64'(hilo_read_data_o), 64'hDEAD_BEEF);
      lat = model_apply(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
      tick();
      op_valid_i = 1'b0;
      check("mthi_no_done", 64'(done_o), 64'd0);
      check("mthi_ready",   64'(op_ready_o), 64'd1);
      check_hilo("mthi", 32'hDEAD_BEEF, 32'd0);

      // MULT / MULTU of 0xFFFFFFFF * 2
      lat = model_apply(OP_MULT, 32'hFFFF_FFFF, 32'd2);
      issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
      check("mult_busy", 64'(busy_o), 64'd1);
      wait_done(20, cyc);
      check("mult_latency", 64'(cyc), 64'(ML));
      check("mult_ready_in_done", 64'(op_ready_o), 64'd1);
      check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      tick();
      check("mult_done_one_cycle", 64'(done_o), 64'd0);

      lat = model_apply(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
      wait_done(20, cyc);
      check("multu_latency", 64'(cyc), 64'(ML));
      check_hilo("multu", 32'd1, 32'hFFFF_FFFE);

      // DIV -7/2 and DIVU by zero
      lat = model_apply(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      wait_done(60, cyc);
      check("div_latency", 64'(cyc), 64'd33);
      check_hilo("div_neg7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      lat = model_apply(OP_DIVU, 32'd7, 32'd0);
      issue(OP_DIVU, 32'd7, 32'd0, 1'b0);
      wait_done(60, cyc);
      check("divu_zero_latency", 64'(cyc), 64'd1);
      check_hilo("divu_zero_kept", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      // Signed MIN / -1
      lat = model_apply(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      wait_done(60, cyc);
      check_hilo("div_min_m1", 32'd0, 32'h8000_0000);

      // MADD: HI:LO = 0:1 plus 3 * -1
      lat = model_apply(OP_MTHI, 32'd0, 32'd0);
      issue(OP_MTHI, 32'd0, 32'd0, 1'b0);
      lat = model_apply(OP_MTLO, 32'd1, 32'd0);
      issue(OP_MTLO, 32'd1, 32'd0, 1'b0);
      lat = model_apply(OP_MADD, 32'd3, 32'hFFFF_FFFF);
      issue(OP_MADD, 32'd3, 32'hFFFF_FFFF, 1'b0);
      wait_done(20, cyc);
      check("madd_latency", 64'(cyc), 64'(ML));
      check_hilo("madd", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

      // Flush at DIV cycle 5
      issue(OP_DIV, 32'd100, 32'd7, 1'b0);
      repeat (4) tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("div_flush_ready", 64'(op_ready_o), 64'd1);
      check("div_flush_busy",  64'(busy_o),     64'd0);
      expect_no_done("div_flush_no_done", 40);
      check_hilo("div_flush_kept", model_hi, model_lo);

      // Flush during MUL
      issue(OP_MULT, 32'd5, 32'd5, 1'b0);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("mul_flush_ready", 64'(op_ready_o), 64'd1);
      expect_no_done("mul_flush_no_done", 5);
      check_hilo("mul_flush_kept", model_hi, model_lo);

      // valid together with flush is dropped, including its forwarded read
      op_valid_i       = 1'b1;
      op_code_i        = OP_MTLO;
      src_a_i          = 32'h1234_5678;
      flush_i          = 1'b1;
      hilo_read_addr_i = 1'b0;
      #1 check("flush_drop_no_forward", 64'(hilo_read_data_o), 64'(model_lo));
      tick();
      issue(OP_DIV, 32'd9, 32'd3, 1'b1);
      check("flush_drop_div_idle", 64'(op_ready_o), 64'd1);
      expect_no_done("flush_drop_no_done", 40);
      check_hilo("flush_drop_kept", model_hi, model_lo);

      // Asynchronous reset at DIV cycle 10
      issue(OP_DIV, 32'd1000, 32'd3, 1'b0);
      repeat (9) tick();
      #2 reset_i = 1'b1;
      #1 check("rst_mid_div_ready", 64'(op_ready_o), 64'd1);
      check("rst_mid_div_done", 64'(done_o), 64'd0);
      check_hilo("rst_mid_div", 32'd0, 32'd0);
      reset_i  = 1'b0;
      model_hi = '0;
      model_lo = '0;
      tick();
      expect_no_done("rst_mid_div_no_done", 40);

      // Randomized back-to-back operations against the model
      for (int i = 0; i < 60; i++) begin
         op  = 3'($urandom_range(0, 7));
         a   = pick_operand();
         b   = pick_operand();
         lat = model_apply(op, a, b);
         issue(op, a, b, 1'b0);
         if (lat == 0) begin
            check("rand_mt_no_done", 64'(done_o), 64'd0);
         end else begin
            wait_done(lat + 5, cyc);
            check("rand_latency", 64'(cyc), 64'(lat));
            check("rand_ready_in_done", 64'(op_ready_o), 64'd1);
         end
         check_hilo("rand", model_hi, model_lo);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
